// File: rtl/fpu_sign_pkg.sv
// Shared types and constants for the FP sign-injection issue front end.
// Holds the sequencer state enum plus RV32F opcode/funct and one-hot op encodings.
package fpu_sign_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [6:0] OPC_OP_FP = 7'b1010011;
    localparam logic [6:0] F7_FSGNJ  = 7'b0010000;

    localparam logic [2:0] F3_SGNJ  = 3'b000;
    localparam logic [2:0] F3_SGNJN = 3'b001;
    localparam logic [2:0] F3_SGNJX = 3'b010;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_SGNJ  = 3'b001;
    localparam logic [2:0] OP_SGNJN = 3'b010;
    localparam logic [2:0] OP_SGNJX = 3'b100;

endpackage

// File: rtl/fpu_sign_decode.sv
// Combinational decoder for FSGNJ/FSGNJN/FSGNJX instruction words.
// Ports: instr (in) -> legal, op one-hot, rs1, rs2, rd (out).
module fpu_sign_decode
    import fpu_sign_pkg::*;
#(
    parameter int RegAw = 5
) (
    input  logic [31:0]      instr,
    output logic             legal,
    output logic [2:0]       op,
    output logic [RegAw-1:0] rs1,
    output logic [RegAw-1:0] rs2,
    output logic [RegAw-1:0] rd
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [2:0] op_raw;
    logic       f3_ok;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    assign rs1 = RegAw'(instr[19:15]);
    assign rs2 = RegAw'(instr[24:20]);
    assign rd  = RegAw'(instr[11:7]);

    always_comb begin
        op_raw = OP_NONE;
        f3_ok  = 1'b0;
        unique case (1'b1)
            (funct3 == F3_SGNJ): begin
                op_raw = OP_SGNJ;
                f3_ok  = 1'b1;
            end
            (funct3 == F3_SGNJN): begin
                op_raw = OP_SGNJN;
                f3_ok  = 1'b1;
            end
            (funct3 == F3_SGNJX): begin
                op_raw = OP_SGNJX;
                f3_ok  = 1'b1;
            end
            default: ;
        endcase
    end

    assign legal = (opcode == OPC_OP_FP)
                && (funct7 == F7_FSGNJ)
                && f3_ok;

    // Keep op quiet for rejected words so nothing downstream sees a stray code.
    assign op = legal ? op_raw : OP_NONE;

endmodule

// File: rtl/fpu_sign_issue.sv
// Issue/sequencing front end for the combinational FP sign-injection unit.
// Ports: clk, rst (sync, active-high); instr_valid/instr/instr_ready handshake;
//   rf_re/rf_raddr/rf_rdata sync read port; sgn_op/sgn_a/sgn_b/sgn_res sign unit;
//   rf_we/rf_waddr/rf_wdata write-back; illegal pulse; busy.
// Macro FPU_SIGN_SAME_REG_EN: when rs1==rs2 skip the second read (3-cycle latency).
module fpu_sign_issue
    import fpu_sign_pkg::*;
#(
    parameter int Std   = 31,
    parameter int RegAw = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             rf_re,
    output logic [RegAw-1:0] rf_raddr,
    input  logic [Std:0]     rf_rdata,
    output logic [2:0]       sgn_op,
    output logic [Std:0]     sgn_a,
    output logic [Std:0]     sgn_b,
    input  logic [Std:0]     sgn_res,
    output logic             rf_we,
    output logic [RegAw-1:0] rf_waddr,
    output logic [Std:0]     rf_wdata,
    output logic             illegal,
    output logic             busy
);

    logic             dec_legal;
    logic [2:0]       dec_op;
    logic [RegAw-1:0] dec_rs1;
    logic [RegAw-1:0] dec_rs2;
    logic [RegAw-1:0] dec_rd;

    fpu_sign_decode #(
        .RegAw (RegAw)
    ) u_decode (
        .instr (instr),
        .legal (dec_legal),
        .op    (dec_op),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .rd    (dec_rd)
    );

    state_t           state;
    logic [2:0]       op_q;
    logic [RegAw-1:0] rs2_q;
    logic [RegAw-1:0] rd_q;
    logic             same_q;
    logic             same_now;
    logic [Std:0]     a_q;
    logic [Std:0]     b_q;

`ifdef FPU_SIGN_SAME_REG_EN
    assign same_now = (dec_rs1 == dec_rs2);
`else
    assign same_now = 1'b0;
`endif

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // The read port returns data one cycle late, so the last operand read
    // only arrives during EXEC. It is forwarded straight to the sign unit
    // that cycle and latched at the end so the operand holds afterwards.
    assign sgn_b = (state == EXEC) ? rf_rdata : b_q;
    assign sgn_a = ((state == EXEC) && same_q) ? rf_rdata : a_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rf_re    <= 1'b0;
            rf_raddr <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            illegal  <= 1'b0;
            sgn_op   <= OP_NONE;
            op_q     <= OP_NONE;
            rs2_q    <= '0;
            rd_q     <= '0;
            same_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            rf_re   <= 1'b0;
            rf_we   <= 1'b0;
            illegal <= 1'b0;
            sgn_op  <= OP_NONE;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (dec_legal) begin
                            op_q     <= dec_op;
                            rs2_q    <= dec_rs2;
                            rd_q     <= dec_rd;
                            same_q   <= same_now;
                            rf_re    <= 1'b1;
                            rf_raddr <= dec_rs1;
                            state    <= RD_A;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (same_q) begin
                        sgn_op <= op_q;
                        state  <= EXEC;
                    end else begin
                        rf_re    <= 1'b1;
                        rf_raddr <= rs2_q;
                        state    <= RD_B;
                    end
                end
                RD_B: begin
                    a_q    <= rf_rdata;
                    sgn_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    b_q <= rf_rdata;
                    if (same_q) begin
                        a_q <= rf_rdata;
                    end
                    rf_wdata <= sgn_res;
                    rf_we    <= 1'b1;
                    rf_waddr <= rd_q;
                    state    <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sign_issue.sv
// Self-checking bench for fpu_sign_issue with RF and sign-unit models.
// Directed and random instructions checked against a funct3-level reference.
module tb_fpu_sign_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        rf_re;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [2:0]  sgn_op;
    logic [31:0] sgn_a;
    logic [31:0] sgn_b;
    logic [31:0] sgn_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        illegal;
    logic        busy;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mdl [32];
    logic [31:0] rf [32];
    logic        init_en;

    fpu_sign_issue #(
        .Std   (31),
        .RegAw (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_re       (rf_re),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .sgn_op      (sgn_op),
        .sgn_a       (sgn_a),
        .sgn_b       (sgn_b),
        .sgn_res     (sgn_res),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 32; i++) rf[i] <= mdl[i];
            rf_rdata <= '0;
        end else begin
            if (rf_re) rf_rdata <= rf[rf_raddr];
            if (rf_we) rf[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        sgn_res = '0;
        if (sgn_op == 3'b001) sgn_res = {sgn_b[31], sgn_a[30:0]};
        else if (sgn_op == 3'b010) sgn_res = {~sgn_b[31], sgn_a[30:0]};
        else if (sgn_op == 3'b100) sgn_res = {sgn_a[31] ^ sgn_b[31], sgn_a[30:0]};
    end

    function automatic logic [31:0] ref_sgn(input int f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        int s;
        sa = a[31] ? 1 : 0;
        sb = b[31] ? 1 : 0;
        if (f3 == 0) s = sb;
        else if (f3 == 1) s = 1 - sb;
        else s = (sa + sb) % 2;
        return (a & 32'h7FFF_FFFF) | ((s == 1) ? 32'h8000_0000 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input logic [31:0] ins, input string tag);
        int f3, rs1, rs2, rd, lat, nrd;
        logic leg;
        logic [31:0] expv;
        int reads, first_ra, last_ra, we_n, we_c, ill_n, ill_c, op_n, op_c, rdy0;
        logic [31:0] wa, wd;
        logic [2:0] opv;
        f3  = int'(ins[14:12]);
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        rd  = int'(ins[11:7]);
        leg = (ins[6:0] == 7'h53) && (ins[31:25] == 7'h10) && (f3 < 3);
        lat = 4;
        nrd = 2;
`ifdef FPU_SIGN_SAME_REG_EN
        if (rs1 == rs2) begin
            lat = 3;
            nrd = 1;
        end
`endif
        expv = ref_sgn(f3, mdl[rs1], mdl[rs2]);
        reads = 0; first_ra = -1; last_ra = -1;
        we_n = 0; we_c = -1; ill_n = 0; ill_c = -1;
        op_n = 0; op_c = -1; rdy0 = 0;
        wa = '0; wd = '0; opv = '0;
        chk({tag, ".ready"}, {31'b0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr = ins;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (rf_re) begin
                reads++;
                if (reads == 1) first_ra = int'(rf_raddr);
                last_ra = int'(rf_raddr);
            end
            if (rf_we) begin
                we_n++; we_c = c; wa = {27'b0, rf_waddr}; wd = rf_wdata;
            end
            if (illegal) begin
                ill_n++; ill_c = c;
            end
            if (sgn_op != 3'b000) begin
                op_n++; op_c = c; opv = sgn_op;
            end
            if (!instr_ready) rdy0++;
            if (c == 1) begin
                instr_valid = 1'b0;
                instr = $urandom;
            end
        end
        if (leg) begin
            chk({tag, ".we_n"}, we_n, 1);
            chk({tag, ".we_lat"}, we_c, lat);
            chk({tag, ".waddr"}, wa, rd);
            chk({tag, ".wdata"}, wd, expv);
            chk({tag, ".reads"}, reads, nrd);
            chk({tag, ".ra1"}, first_ra, rs1);
            chk({tag, ".ra2"}, last_ra, (nrd == 2) ? rs2 : rs1);
            chk({tag, ".op_n"}, op_n, 1);
            chk({tag, ".op_cyc"}, op_c, lat - 1);
            chk({tag, ".op"}, {29'b0, opv}, 32'd1 << f3);
            chk({tag, ".ill"}, ill_n, 0);
            chk({tag, ".busy"}, rdy0, lat);
            mdl[rd] = expv;
        end else begin
            chk({tag, ".ill_n"}, ill_n, 1);
            chk({tag, ".ill_cyc"}, ill_c, 1);
            chk({tag, ".reads"}, reads, 0);
            chk({tag, ".we_n"}, we_n, 0);
            chk({tag, ".op_n"}, op_n, 0);
            chk({tag, ".busy"}, rdy0, 0);
        end
    endtask

    initial begin
        int zero, first_rdy, we1, we2, wen, mism, r, rs1, rs2, rd, f3;
        logic [31:0] wd1, wd2, ins;
        rst = 1'b1;
        init_en = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        for (int i = 0; i < 32; i++) mdl[i] = $urandom;
        mdl[1] = 32'h3F80_0000;
        mdl[2] = 32'hC000_0000;

        repeat (3) @(negedge clk);
        chk("rst.ready", {31'b0, instr_ready}, 32'd1);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.rf_re", {31'b0, rf_re}, 32'd0);
        chk("rst.rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst.illegal", {31'b0, illegal}, 32'd0);
        chk("rst.sgn_op", {29'b0, sgn_op}, 32'd0);
        chk("rst.sgn_a", sgn_a, 32'd0);
        chk("rst.sgn_b", sgn_b, 32'd0);
        chk("rst.waddr", {27'b0, rf_waddr}, 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        rst = 1'b0;
        init_en = 1'b0;
        @(negedge clk);

        run_one(32'h2020_81D3, "fsgnj");
        chk("fsgnj.val", mdl[3], 32'hBF80_0000);
        run_one(32'h2020_91D3, "fsgnjn");
        chk("fsgnjn.val", mdl[3], 32'h3F80_0000);
        run_one(32'h2020_A1D3, "fsgnjx");
        chk("fsgnjx.val", mdl[3], 32'hBF80_0000);
        run_one(32'h0020_81D3, "fadd");
        run_one(32'h2010_9253, "fneg");
        chk("fneg.val", mdl[4], 32'hBF80_0000);
        run_one({7'h10, 5'd2, 5'd1, 3'd0, 5'd0, 7'h53}, "rd0");
        run_one({7'h10, 5'd7, 5'd7, 3'd2, 5'd7, 7'h53}, "same3");

        // back-to-back with valid held high
        zero = 0; first_rdy = 0; we1 = 0; we2 = 0;
        wd1 = '0; wd2 = '0;
        instr_valid = 1'b1;
        instr = 32'h2020_81D3;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (first_rdy == 0) begin
                if (instr_ready) first_rdy = c;
                else zero++;
            end
            if (rf_we) begin
                if (we1 == 0) begin
                    we1 = c; wd1 = rf_wdata;
                end else begin
                    we2 = c; wd2 = rf_wdata;
                end
            end
            if (c == 1) instr = 32'h2020_A2D3;
            if (first_rdy != 0 && c == first_rdy + 1) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        chk("b2b.busy", zero, 4);
        chk("b2b.accept2", first_rdy, 5);
        chk("b2b.we1", we1, 4);
        chk("b2b.wd1", wd1, ref_sgn(0, mdl[1], mdl[2]));
        chk("b2b.we2", we2, 9);
        chk("b2b.wd2", wd2, ref_sgn(2, mdl[1], mdl[2]));
        mdl[3] = ref_sgn(0, mdl[1], mdl[2]);
        mdl[5] = ref_sgn(2, mdl[1], mdl[2]);

        // reset while in EXEC
        instr_valid = 1'b1;
        instr = 32'h2020_8353;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) instr_valid = 1'b0;
        end
        chk("rstx.exec_op", {29'b0, sgn_op}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx.ready", {31'b0, instr_ready}, 32'd1);
        chk("rstx.busy", {31'b0, busy}, 32'd0);
        chk("rstx.rf_re", {31'b0, rf_re}, 32'd0);
        chk("rstx.rf_we", {31'b0, rf_we}, 32'd0);
        chk("rstx.sgn_op", {29'b0, sgn_op}, 32'd0);
        chk("rstx.sgn_a", sgn_a, 32'd0);
        chk("rstx.sgn_b", sgn_b, 32'd0);
        chk("rstx.wdata", rf_wdata, 32'd0);
        rst = 1'b0;
        wen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rf_we) wen++;
        end
        chk("rstx.no_we", wen, 0);

        // random mix of legal and illegal words
        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 9);
            rs1 = $urandom_range(0, 31);
            rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom_range(0, 31);
            rd  = $urandom_range(0, 31);
            f3  = $urandom_range(0, 2);
            ins = {7'h10, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h53};
            if (r == 7) ins[14:12] = 3'($urandom_range(3, 7));
            if (r == 8) ins[31:25] = 7'h10 ^ 7'($urandom_range(1, 127));
            if (r == 9) ins[6:0] = 7'h53 ^ 7'($urandom_range(1, 127));
            run_one(ins, "rand");
        end

        mism = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== mdl[i]) mism++;
        chk("rf_final", mism, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
